fixed_pt_divider: RTL and testbench
===================================

FIXED_PT_DIVIDER -- requirements
Module: fixed_pt_divider

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 24, meaning the bit width of dividend, divisor and quotient.
REQ-002 SHALL have parameter DECIMAL_PLACE, default 8, meaning the number of fractional bits in every operand and the result (unsigned Q(OPERAND_WIDTH-DECIMAL_PLACE).DECIMAL_PLACE).
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; a division begins when sampled high while busy is low.
REQ-006 SHALL have port dividend  input  OPERAND_WIDTH  unsigned fixed-point numerator, sampled with start.
REQ-007 SHALL have port divisor  input  OPERAND_WIDTH  unsigned fixed-point denominator, sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking quotient and flags valid.
REQ-010 SHALL have port quotient  output  OPERAND_WIDTH  fixed-point result, held until the next accepted start.
REQ-011 SHALL have port div_by_zero  output  1  high with done when divisor was zero; held like quotient.
REQ-012 SHALL have port overflow  output  1  high with done when the result exceeded OPERAND_WIDTH bits; held like quotient.

Function
REQ-013 SHALL compute quotient = floor((dividend << DECIMAL_PLACE) / divisor), the exact inverse of the team's fixed-point multiplier format.
REQ-014 SHALL implement an FSM with states IDLE, DIVIDE, FINISH: IDLE->DIVIDE on accepted start with nonzero divisor; IDLE->FINISH on accepted start with zero divisor; DIVIDE->FINISH after the last iteration; FINISH->IDLE unconditionally.
REQ-015 SHALL perform iterative restoring division, one quotient bit per cycle, OPERAND_WIDTH+DECIMAL_PLACE iterations (32 at defaults), using a remainder register of OPERAND_WIDTH+1 bits.
REQ-016 SHALL, with start accepted in cycle 0 and nonzero divisor, assert done in cycle OPERAND_WIDTH+DECIMAL_PLACE+1 (cycle 33 at defaults), quotient and flags updated in the same cycle.
REQ-017 SHALL, for zero divisor, assert done in cycle 1 with quotient all-ones, div_by_zero=1, overflow=0.
REQ-018 SHALL, when any of the upper DECIMAL_PLACE bits of the full OPERAND_WIDTH+DECIMAL_PLACE-bit quotient is nonzero, saturate quotient to all-ones and set overflow=1.
REQ-019 SHALL ignore start while busy is high or during the FINISH cycle; in-flight operands SHALL NOT change.
REQ-020 SHALL keep busy low in IDLE and high in DIVIDE and FINISH; done SHALL be high only in FINISH.
REQ-021 SHALL clear div_by_zero and overflow at every accepted start.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-division, immediately force state IDLE, busy=0, done=0, quotient=0, div_by_zero=0, overflow=0, aborting any operation with no done pulse.
REQ-023 SHALL accept a start on the first rising clk edge after rst_n deasserts.

Configuration
REQ-024 SHALL support macro FIXED_PT_DIVIDER_ROUND_EN: when defined, one extra guard-bit iteration is performed (done in cycle OPERAND_WIDTH+DECIMAL_PLACE+2), the result is rounded half-up, and a rounding carry out of OPERAND_WIDTH bits saturates to all-ones with overflow=1.
REQ-025 SHALL, when FIXED_PT_DIVIDER_ROUND_EN is undefined, truncate toward zero with latency per REQ-016; zero-divisor latency (REQ-017) SHALL be unchanged in both builds.

Verification
REQ-026 SHALL cover dividend=0x93D000, divisor=0xDC00 -> quotient=0x00AC00, done in cycle 33, flags 0.
REQ-027 SHALL cover dividend=0x018480, divisor=0x1500 -> quotient=0x001280, flags 0.
REQ-028 SHALL cover dividend=0x000200, divisor=0x000300 -> quotient=0x0000AA without macro, 0x0000AB with FIXED_PT_DIVIDER_ROUND_EN.
REQ-029 SHALL cover dividend=0x000100, divisor=0 -> done in cycle 1, quotient=0xFFFFFF, div_by_zero=1; then dividend=0xFFFFFF, divisor=0x000001 -> quotient=0xFFFFFF, overflow=1, div_by_zero=0.
REQ-030 SHALL cover start re-asserted with new operands at cycle 10 of a division -> ignored, original result delivered; and rst_n pulsed low at cycle 15 -> all outputs 0, no done pulse, next start completes normally.

Source files
------------

// File: rtl/fixed_pt_divider.sv
// Unsigned fixed-point divider: quotient = floor((dividend << DECIMAL_PLACE) / divisor),
// one restoring-division step per cycle. Define FIXED_PT_DIVIDER_ROUND_EN for round-half-up.
`timescale 1ns/1ps
module fixed_pt_divider #(
  parameter int unsigned OPERAND_WIDTH = 24,
  parameter int unsigned DECIMAL_PLACE = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [OPERAND_WIDTH-1:0] dividend,
  input  logic [OPERAND_WIDTH-1:0] divisor,
  output logic                     busy,
  output logic                     done,
  output logic [OPERAND_WIDTH-1:0] quotient,
  output logic                     div_by_zero,
  output logic                     overflow
);

  localparam int unsigned W = OPERAND_WIDTH;
`ifdef FIXED_PT_DIVIDER_ROUND_EN
  localparam int unsigned GUARD = 1;
`else
  localparam int unsigned GUARD = 0;
`endif
  localparam int unsigned ITER = W + DECIMAL_PLACE + GUARD;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t            state_q;
  logic [W:0]        rem_q;
  logic [ITER-1:0]   acc_q;
  logic [W-1:0]      div_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [W-1:0]      quot_q;
  logic              dz_q;
  logic              ov_q;

  logic [W+1:0]      rem_shift;
  logic [W:0]        trial;
  logic              fits;
  logic [W:0]        rem_d;
  logic [ITER-1:0]   acc_d;
  logic [ITER-1:0]   rounded;
  logic              last;
  logic              ovf_d;
  logic [W-1:0]      quot_d;

  // acc_q shifts numerator bits out of the top while quotient bits enter at the bottom
  always_comb begin
    rem_shift = {rem_q, acc_q[ITER-1]};
    fits      = rem_shift >= {2'b00, div_q};
    trial     = rem_shift[W:0] - {1'b0, div_q};
    rem_d     = fits ? trial : rem_shift[W:0];
    acc_d     = {acc_q[ITER-2:0], fits};
    last      = (cnt_q == CW'(ITER - 1));
`ifdef FIXED_PT_DIVIDER_ROUND_EN
    // acc_d holds twice the quotient; adding the guard bit rounds half-up
    rounded   = (acc_d >> 1) + ITER'(acc_d[0]);
`else
    rounded   = acc_d;
`endif
    ovf_d     = (rounded >> W) != '0;
    quot_d    = ovf_d ? '1 : rounded[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            ov_q   <= 1'b0;
            if (divisor == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
              quot_q  <= '1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= DIVIDE;
              dz_q    <= 1'b0;
              rem_q   <= '0;
              acc_q   <= ITER'(dividend) << (ITER - W);
              div_q   <= divisor;
              cnt_q   <= '0;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            quot_q  <= quot_d;
            ov_q    <= ovf_d;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_fixed_pt_divider.sv
// Self-checking bench for fixed_pt_divider; follows FIXED_PT_DIVIDER_ROUND_EN when defined.
`timescale 1ns/1ps
module tb_fixed_pt_divider;
  localparam int unsigned W  = 24;
  localparam int unsigned DP = 8;
`ifdef FIXED_PT_DIVIDER_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = int'(W + DP + 1) + (RND ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient;

  int checks = 0;
  int failures = 0;

  fixed_pt_divider #(.OPERAND_WIDTH(W), .DECIMAL_PLACE(DP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on the scaled numerator.
  function automatic void model(input longint unsigned dd, input longint unsigned dv,
                                output logic [W-1:0] q, output logic dz, output logic ov);
    longint unsigned num, maxq, r;
    num  = dd << DP;
    maxq = (64'd1 << W) - 1;
    if (dv == 0) begin
      q = '1; dz = 1'b1; ov = 1'b0;
    end else begin
      r  = RND ? (2 * num + dv) / (2 * dv) : num / dv;
      dz = 1'b0;
      ov = (r > maxq);
      q  = ov ? '1 : W'(r);
    end
  endfunction

  // Issues one division and measures latency; comparisons are left to the callers.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, output int lat,
                         output logic [W-1:0] q, output logic dz, output logic ov,
                         output bit busy_ok, output bit pulse_ok, output logic [1:0] flags1);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    #1 start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    lat = 0; busy_ok = 1'b1; flags1 = 2'b11;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge clk);
      if (c == 1) flags1 = {div_by_zero, overflow};
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin lat = c; break; end
    end
    q = quotient; dz = div_by_zero; ov = overflow;
    @(negedge clk);
    pulse_ok = (done === 1'b0) && (busy === 1'b0) && (quotient === q);
  endtask

  task automatic check_op(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv);
    int lat; logic [W-1:0] q, eq; logic dz, ov, edz, eov; bit bok, pok; logic [1:0] f1;
    int elat;
    model(dd, dv, eq, edz, eov);
    elat = (dv == 0) ? 1 : LAT;
    run_div(dd, dv, lat, q, dz, ov, bok, pok, f1);
    checks++;
    if ({q, dz, ov} !== {eq, edz, eov}) begin
      failures++;
      $display("FAIL %s result dd=%h dv=%h got q=%h dz=%b ov=%b exp q=%h dz=%b ov=%b",
               name, dd, dv, q, dz, ov, eq, edz, eov);
    end
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat);
    end
    checks++;
    if (!(bok && pok)) begin
      failures++;
      $display("FAIL %s handshake busy_ok=%0d pulse_ok=%0d exp 1 1", name, bok, pok);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {busy, done, div_by_zero, overflow, quotient});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] dd [3] = '{24'h93D000, 24'h018480, 24'h000200};
    logic [W-1:0] dv [3] = '{24'h00DC00, 24'h001500, 24'h000300};
    logic [W-1:0] ex [3];
    int lat; logic [W-1:0] q; logic dz, ov; bit bok, pok; logic [1:0] f1;
    ex = '{24'h00AC00, 24'h001280, RND ? 24'h0000AB : 24'h0000AA};
    for (int i = 0; i < 3; i++) begin
      run_div(dd[i], dv[i], lat, q, dz, ov, bok, pok, f1);
      checks++;
      if ({q, dz, ov} !== {ex[i], 2'b00}) begin
        failures++;
        $display("FAIL directed%0d got q=%h dz=%b ov=%b exp q=%h dz=0 ov=0", i, q, dz, ov, ex[i]);
      end
      checks++;
      if (lat !== LAT || !bok || !pok) begin
        failures++;
        $display("FAIL directed%0d timing got lat=%0d busy_ok=%0d pulse_ok=%0d exp lat=%0d 1 1",
                 i, lat, bok, pok, LAT);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat; logic [W-1:0] q; logic dz, ov; bit bok, pok; logic [1:0] f1;
    run_div(24'h000100, '0, lat, q, dz, ov, bok, pok, f1);
    checks++;
    if ({q, dz, ov} !== {24'hFFFFFF, 2'b10} || lat !== 1 || !pok) begin
      failures++;
      $display("FAIL div_by_zero got q=%h dz=%b ov=%b lat=%0d pulse_ok=%0d exp q=ffffff dz=1 ov=0 lat=1 1",
               q, dz, ov, lat, pok);
    end
    run_div(24'hFFFFFF, 24'h000001, lat, q, dz, ov, bok, pok, f1);
    checks++;
    if (f1 !== 2'b00) begin
      failures++;
      $display("FAIL flags_clear_on_start got=%b exp=00", f1);
    end
    checks++;
    if ({q, dz, ov} !== {24'hFFFFFF, 2'b01} || lat !== LAT) begin
      failures++;
      $display("FAIL overflow got q=%h dz=%b ov=%b lat=%0d exp q=ffffff dz=0 ov=1 lat=%0d",
               q, dz, ov, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] dd, dv;
    int mode;
    for (int i = 0; i < 40; i++) begin
      dd   = W'($urandom);
      mode = int'($urandom_range(0, 7));
      if (mode == 0)      dv = '0;
      else if (mode < 3)  dv = W'($urandom_range(1, 255));
      else if (mode < 5)  dv = W'($urandom_range(256, 65535));
      else                dv = W'($urandom) | 24'h1;
      check_op($sformatf("random%0d", i), dd, dv);
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] dd, dv, eq, q; logic edz, eov, dz, ov;
    int lat;
    dd = W'($urandom); dv = W'($urandom_range(256, 65535));
    model(dd, dv, eq, edz, eov);
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; dividend = W'($urandom); divisor = 24'h000001;
      end
      if (done === 1'b1) begin lat = c; break; end
    end
    q = quotient; dz = div_by_zero; ov = overflow;
    checks++;
    if ({q, dz, ov} !== {eq, edz, eov} || lat !== LAT) begin
      failures++;
      $display("FAIL ignore_start got q=%h dz=%b ov=%b lat=%0d exp q=%h dz=%b ov=%b lat=%0d",
               q, dz, ov, lat, eq, edz, eov, LAT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_finish got busy=%b done=%b exp busy=0 done=0", busy, done);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start = 1'b1; dividend = 24'h93D000; divisor = 24'h00DC00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, quotient} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=0", {busy, done, div_by_zero, overflow, quotient});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_abort got active_cycles=%0d exp=0", pulses);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_op("after_reset", 24'h018480, 24'h001500);
  endtask

  task automatic test_back_to_back();
    check_op("b2b_a", 24'h000200, 24'h000300);
    check_op("b2b_b", 24'h000000, 24'h000007);
    check_op("b2b_c", 24'h000005, 24'h000000);
    check_op("b2b_d", 24'hFFFFFF, 24'hFFFFFF);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
